// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the convolution engine.
package cnn_pkg;

  // Controller states, in job order.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HDR,
    ST_LD_W,
    ST_CONV,
    ST_WR,
    ST_DONE
  } state_t;

  // Width of the image-side field in the header word (N lives in bits [7:0]).
  localparam int HDR_W = 8;

  // Working width for rounding/saturation; wide enough for any legal ACC_W.
  localparam int CALC_W = 64;

  // Round-half-up by 2^(frac-1), arithmetic shift right by frac, then clamp
  // to the signed range of a data_w-bit sample.
  function automatic logic signed [CALC_W-1:0] sat_round(
    input logic signed [CALC_W-1:0] acc,
    input int                       frac,
    input int                       data_w
  );
    logic signed [CALC_W-1:0] rounded;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    if (frac > 0) rounded = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    else          rounded = acc;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (rounded > hi)      sat_round = hi;
    else if (rounded < lo) sat_round = lo;
    else                   sat_round = rounded;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate unit: one sample x weight product per enabled
// cycle, accumulator restarts from the product when clr is high.
module conv_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       sample,
  input  logic [DATA_W-1:0]       weight,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  // Full-precision signed product, sign-extended to accumulator width.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results in the same evaluation; clocked state below uses '<=' instead.
    prod     = $signed(sample) * $signed(weight);
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  // Accumulator register: load on first product of a pixel, add otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (en)  acc <= clr ? prod_ext : acc + prod_ext;
  end

endmodule

// File: rtl/cnn_conv_core.sv
// Single-layer valid-mode KxK convolution engine. Reads the image header and
// kernel, then for each output pixel streams the KxK window through the MAC,
// rounds/saturates/ReLUs the sum and writes it back to SRAM.
module cnn_conv_core
  import cnn_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                FRAC     = 8,
  parameter int                ADDR_W   = 12,
  parameter int                K        = 3,
  parameter int                ACC_W    = 40,
  parameter logic [ADDR_W-1:0] OUT_BASE = 12'h200,
  parameter bit                RELU_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  localparam int KK    = K * K;
  localparam int IDX_W = $clog2(KK + 1);
  localparam int KR_W  = (K > 1) ? $clog2(K) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KK);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [KR_W-1:0]  K_LAST   = KR_W'(K - 1);
  localparam logic [HDR_W-1:0] K_HDR    = HDR_W'(K);
  localparam logic [HDR_W-1:0] HDR_ONE  = HDR_W'(1);

  state_t state_q, state_d;

  // Phase counter: header phase (0/1), weight index, or window tap index.
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  tap;
  logic [HDR_W-1:0]  n_q, p_q;
  logic [HDR_W-1:0]  row_q, col_q;
  logic [KR_W-1:0]   kr_q, kc_q;
  logic [HDR_W-1:0]  hdr_n;

  logic [ADDR_W-1:0] sram_addr_q, wmem_addr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] kernel [KK];

  logic              sram_issue, wmem_issue, kern_load, mac_en, mac_clr, wr_now;
  logic              last_pix;
  logic [ADDR_W-1:0] pix_addr, out_addr, sram_issue_addr;

  logic signed [ACC_W-1:0]  acc;
  logic signed [CALC_W-1:0] rounded;
  logic [DATA_W-1:0]        result;

  // Address arithmetic and end-of-map detection; everything wraps mod 2^ADDR_W.
  always_comb begin
    hdr_n    = sram_dut_read_data[HDR_W-1:0];
    tap      = idx_q - IDX_ONE;
    pix_addr = ADDR_W'(1)
             + (ADDR_W'(row_q) + ADDR_W'(kr_q)) * ADDR_W'(n_q)
             + ADDR_W'(col_q) + ADDR_W'(kc_q);
    out_addr = OUT_BASE + ADDR_W'(row_q) * ADDR_W'(p_q) + ADDR_W'(col_q);
    last_pix = (row_q == p_q - HDR_ONE) && (col_q == p_q - HDR_ONE);
  end

  // Post-processing of the finished sum: round, saturate, optional ReLU.
  always_comb begin
    rounded = sat_round(CALC_W'(acc), FRAC, DATA_W);
    if (RELU_EN && rounded < 0) rounded = '0;
    result = DATA_W'(rounded);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (!reset_b) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (dut_run) state_d = ST_RD_HDR;
      ST_RD_HDR: if (idx_q != '0) state_d = (hdr_n < K_HDR) ? ST_DONE : ST_LD_W;
      ST_LD_W:   if (idx_q == IDX_LAST) state_d = ST_CONV;
      ST_CONV:   if (idx_q == IDX_LAST) state_d = ST_WR;
      ST_WR:     state_d = last_pix ? ST_DONE : ST_CONV;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sram_issue = 1'b0;
    wmem_issue = 1'b0;
    kern_load  = 1'b0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    wr_now     = 1'b0;
    case (state_q)
      ST_RD_HDR: sram_issue = (idx_q == '0);
      ST_LD_W: begin
        wmem_issue = (idx_q != IDX_LAST);
        kern_load  = (idx_q != '0);
      end
      ST_CONV: begin
        sram_issue = (idx_q != IDX_LAST);
        mac_en     = (idx_q != '0);
        mac_clr    = (idx_q == IDX_ONE);
      end
      ST_WR:   wr_now = 1'b1;
      default: ;
    endcase
  end

  // Output drive: live values while issuing/writing, held values otherwise.
  always_comb begin
    sram_issue_addr        = (state_q == ST_RD_HDR) ? '0 : pix_addr;
    dut_busy               = (state_q != ST_IDLE);
    dut_sram_read_address  = sram_issue ? sram_issue_addr : sram_addr_q;
    dut_wmem_read_address  = wmem_issue ? ADDR_W'(idx_q) : wmem_addr_q;
    dut_sram_write_enable  = wr_now;
    dut_sram_write_address = wr_now ? out_addr : waddr_q;
    dut_sram_write_data    = wr_now ? result : wdata_q;
  end

  // Counters, header capture and held output values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      idx_q       <= '0;
      n_q         <= '0;
      p_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      sram_addr_q <= '0;
      wmem_addr_q <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: idx_q <= '0;
        ST_RD_HDR: begin
          if (idx_q == '0) begin
            idx_q <= IDX_ONE;
          end else begin
            idx_q <= '0;
            n_q   <= hdr_n;
            p_q   <= hdr_n - K_HDR + HDR_ONE;
          end
        end
        ST_LD_W: begin
          if (idx_q == IDX_LAST) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        ST_CONV: begin
          idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
          // Window walk is row-major; both counters wrap back to 0 after
          // the last tap, ready for the next pixel.
          if (sram_issue) begin
            if (kc_q == K_LAST) begin
              kc_q <= '0;
              kr_q <= (kr_q == K_LAST) ? '0 : kr_q + KR_W'(1);
            end else begin
              kc_q <= kc_q + KR_W'(1);
            end
          end
        end
        ST_WR: begin
          if (col_q == p_q - HDR_ONE) begin
            col_q <= '0;
            row_q <= row_q + HDR_ONE;
          end else begin
            col_q <= col_q + HDR_ONE;
          end
        end
        default: ;
      endcase
      if (sram_issue) sram_addr_q <= sram_issue_addr;
      if (wmem_issue) wmem_addr_q <= dut_wmem_read_address;
      if (wr_now) begin
        waddr_q <= out_addr;
        wdata_q <= result;
      end
    end
  end

  // Kernel register file, filled one cycle after each weight address.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; every entry is rewritten during
    // weight load before any convolution reads it.
    if (kern_load) kernel[tap] <= wmem_dut_read_data;
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (reset_b),
    .en     (mac_en),
    .clr    (mac_clr),
    .sample (sram_dut_read_data),
    .weight (kernel[tap]),
    .acc    (acc)
  );

endmodule

// File: tb/tb_cnn_conv_core.sv
// Self-checking bench for cnn_conv_core: SRAM/WMEM models, a convolution
// reference model feeding a write scoreboard, and a write monitor.
module tb_cnn_conv_core;

  localparam int          DATA_W   = 16;
  localparam int          FRAC     = 8;
  localparam int          ADDR_W   = 12;
  localparam int          K        = 3;
  localparam int          ACC_W    = 40;
  localparam logic [11:0] OUT_BASE = 12'h200;
  localparam bit          RELU_EN  = 1'b1;
  localparam int          KK       = K * K;
  localparam int          MAXN     = 8;

  logic              clk;
  logic              reset_b;
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_wmem_read_address;
  logic [DATA_W-1:0] wmem_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dut_sram_write_enable;

  cnn_conv_core #(
    .DATA_W   (DATA_W),
    .FRAC     (FRAC),
    .ADDR_W   (ADDR_W),
    .K        (K),
    .ACC_W    (ACC_W),
    .OUT_BASE (OUT_BASE),
    .RELU_EN  (RELU_EN)
  ) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: synchronous read, data one cycle after address.
  logic [DATA_W-1:0] sram [0:4095];
  logic [DATA_W-1:0] wmem [0:4095];
  always @(posedge clk) begin
    sram_dut_read_data <= sram[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
  end

  // Reference image and kernel for the current job.
  logic signed [DATA_W-1:0] img [0:MAXN-1][0:MAXN-1];
  logic signed [DATA_W-1:0] ker [0:K-1][0:K-1];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  // Output pixel from the plain convolution sum, then Q8 rounding, clamp, ReLU.
  function automatic logic [DATA_W-1:0] ref_pixel(input int r, input int c);
    longint s = 0;
    longint v;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(img[r+i][c+j]) * longint'(ker[i][j]);
    v = (s + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    if (RELU_EN && v < 0) v = 0;
    return DATA_W'(v);
  endfunction

  // Place the job in memory and queue the writes it must produce.
  task automatic setup_job(input int n);
    int  p;
    wr_t e;
    sram[0] = {8'hA5, 8'(n)};
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        sram[1 + r*n + c] = img[r][c];
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        wmem[i*K + j] = ker[i][j];
    if (n >= K) begin
      p = n - K + 1;
      for (int r = 0; r < p; r++)
        for (int c = 0; c < p; c++) begin
          e.addr = ADDR_W'(int'(OUT_BASE) + r*p + c);
          e.data = ref_pixel(r, c);
          exp_q.push_back(e);
        end
    end
  endtask

  // Start a job, optionally hammer dut_run while busy, and measure busy length.
  task automatic run_job(input int n, input int noise);
    int cycles;
    int expect_busy;
    int p;
    setup_job(n);
    p = n - K + 1;
    expect_busy = (n < K) ? 3 : 2 + (KK + 1) + p*p*(KK + 2) + 1;
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
    cycles = 0;
    while (dut_busy && cycles < 5000) begin
      cycles++;
      dut_run = (cycles < noise) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    dut_run = 1'b0;
    check("busy_cycles", cycles, expect_busy);
    check("writes_outstanding", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("idle_after_job", dut_busy, 0);
  endtask

  task automatic fill_img_const(input logic [DATA_W-1:0] v);
    for (int r = 0; r < MAXN; r++)
      for (int c = 0; c < MAXN; c++) img[r][c] = v;
  endtask

  task automatic fill_ker_const(input logic [DATA_W-1:0] v);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) ker[i][j] = v;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  dut_busy, 0);
    check({tag, "_we"},    dut_sram_write_enable, 0);
    check({tag, "_raddr"}, dut_sram_read_address, 0);
    check({tag, "_waddr"}, dut_wmem_read_address, 0);
    check({tag, "_oaddr"}, dut_sram_write_address, 0);
    check({tag, "_odata"}, dut_sram_write_data, 0);
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_b && dut_sram_write_enable) begin
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", dut_sram_write_address, mon_e.addr);
        check("wr_data", dut_sram_write_data, mon_e.data);
      end
    end
  end

  initial begin
    reset_b = 1'b0;
    dut_run = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      sram[a] = '0;
      wmem[a] = '0;
    end
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset_b = 1'b1;

    // Unity image and kernel: every output is 9.0.
    fill_img_const(16'h0100);
    fill_ker_const(16'h0100);
    run_job(4, 0);

    // Positive saturation.
    fill_img_const(16'h7FFF);
    fill_ker_const(16'h7FFF);
    run_job(3, 0);

    // Negative saturation, clamped to zero by ReLU.
    fill_ker_const(16'h8000);
    run_job(3, 0);

    // -1.0 kernel on positive inputs.
    for (int r = 0; r < MAXN; r++)
      for (int c = 0; c < MAXN; c++) img[r][c] = DATA_W'($urandom_range(1, 16'h7FFF));
    fill_ker_const(16'hFF00);
    run_job(5, 0);

    // Degenerate maps: no writes, three busy cycles.
    run_job(2, 0);
    run_job(0, 0);

    // Reset in the middle of the first window of a job.
    fill_img_const(16'h0180);
    fill_ker_const(16'h0040);
    setup_job(5);
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
    repeat (2 + KK + 1 + 4) @(posedge clk);
    #1 check("mid_conv_busy", dut_busy, 1);
    reset_b = 1'b0;
    #1 check_outputs_zero("mid_reset");
    exp_q.delete();
    @(posedge clk); #1 reset_b = 1'b1;
    run_job(5, 0);

    // Ramp image, identity-centre kernel, dut_run hammered while busy.
    for (int r = 0; r < MAXN; r++)
      for (int c = 0; c < MAXN; c++) img[r][c] = DATA_W'(r*6 + c);
    fill_ker_const(16'h0000);
    ker[K/2][K/2] = 16'h0100;
    run_job(6, 40);

    // Random jobs.
    for (int t = 0; t < 5; t++) begin
      int n;
      n = $urandom_range(K, MAXN);
      for (int r = 0; r < MAXN; r++)
        for (int c = 0; c < MAXN; c++) img[r][c] = DATA_W'($urandom);
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) ker[i][j] = DATA_W'($urandom_range(0, 1023)) - 16'd512;
      run_job(n, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_conv_core.md
# cnn_conv_core

Parametrised single-layer convolution engine for the CNN accelerator; successor to the fixed 3x3 datapath/controller pair. On `dut_run` it reads an image header and NxN input feature map from input SRAM, loads a KxK kernel from weight memory into registers, and writes the valid-mode (N-K+1)^2 output map back to SRAM. Output is fixed-point with rounding, saturation and optional ReLU. It sits directly between the SRAM/weight-memory models and the testbench `dut_run`/`dut_busy` handshake.

## Interface
- `DATA_W`, 16, signed sample/weight width (Q(DATA_W-FRAC).FRAC)
- `FRAC`, 8, fractional bits in samples and weights
- `ADDR_W`, 12, SRAM/WMEM address width
- `K`, 3, kernel side (2..7)
- `ACC_W`, 40, accumulator width (≥ 2*DATA_W + ceil(log2(K*K)))
- `OUT_BASE`, 12'h200, first output write address
- `RELU_EN`, 1, clamp negative results to 0 when 1

- `clk` in 1: single clock, rising edge
- `reset_b` in 1: asynchronous, active-low reset
- `dut_run` in 1: start request, sampled only in IDLE
- `dut_busy` out 1: high from cycle after accepted start until job done
- `dut_sram_read_address` out ADDR_W: input SRAM read address
- `sram_dut_read_data` in DATA_W: read data, valid 1 cycle after address
- `dut_wmem_read_address` out ADDR_W: weight memory read address
- `wmem_dut_read_data` in DATA_W: weight data, valid 1 cycle after address
- `dut_sram_write_address` out ADDR_W: output write address
- `dut_sram_write_data` out DATA_W: output sample
- `dut_sram_write_enable` out 1: one-cycle write strobe

## Operation
- Memory map: SRAM[0][7:0] = N; input pixel (r,c) at 1 + r*N + c; weight (i,j) at WMEM[i*K + j]; output (r,c) at OUT_BASE + r*P + c, P = N-K+1. Address arithmetic wraps mod 2^ADDR_W.
- States: IDLE → RD_HDR → LD_W → CONV → WR → (CONV | DONE) → IDLE.
- IDLE: busy 0; `dut_run`=1 → RD_HDR.
- RD_HDR: issue addr 0, capture N next cycle. If N < K (incl. N=0) → DONE, no writes.
- LD_W: issue K*K weight addresses on consecutive cycles; latch each into kernel register file one cycle later.
- CONV: per output pixel, issue K*K input addresses on consecutive cycles (row-major within window); each returned sample MACs with its weight; accumulator cleared at first product of each pixel.
- WR: result = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic), saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then ReLU if RELU_EN; write_enable high exactly one cycle. Next pixel column-first, then row; after (P-1,P-1) → DONE.
- DONE: one cycle, busy drops on exit to IDLE.
- `dut_run` while busy: ignored. `dut_run` held high in IDLE after DONE: starts new job.
- Reset (any state): outputs and state clear immediately; in-flight write is aborted.

## Timing
- Reset values: all outputs 0; state IDLE.
- Start cycle t (dut_run sampled): busy=1 from t+1.
- Header: 2 cycles; weight load: K*K+1 cycles.
- Per output pixel: K*K issue + 1 drain + 1 write = K*K+2 cycles; write address/data valid same cycle as write_enable.
- Total busy cycles = 2 + (K*K+1) + P^2*(K*K+2) + 1; for N<K: 3.
- Read addresses hold last value when not issuing; write data/address hold last written value.

## Structure
- `cnn_pkg`: state enum, `sat_round` function (round-shift-saturate), widths derived from parameters.
- Sub-module `conv_mac`: signed DATA_W×DATA_W multiply, ACC_W accumulate, clear/enable inputs, registered output.
- Address generation (row/col/kr/kc counters) and FSM in `cnn_conv_core`.

## Test plan
- K=3, N=4, all inputs 0x0100, weights 0x0100 → 4 writes of 0x0900 at 0x200..0x203; busy 2+10+4*11+1=57 cycles.
- Inputs 0x7FFF, weights 0x7FFF, N=3 → single write 0x7FFF (saturation); with weights 0x8000 and RELU_EN=0 → 0x8000.
- RELU_EN=1, weights all 0xFF00 (-1.0), positive inputs → all outputs 0x0000.
- N=2 with K=3 → no write strobes, busy high exactly 3 cycles.
- Assert reset_b low mid-CONV → all outputs 0 same cycle; then dut_run → full correct job.
- Pulse dut_run repeatedly while busy → exactly one job's writes; ramp input r*N+c with identity-centre kernel → outputs equal window-centre values.
